prog_loader: RTL

- Boot and program loader for the soft MPU. It sits upstream of the controller and drives the controller's restart and start inputs.
- Accepts a length-prefixed byte stream from a host over a valid/ready handshake and writes the bytes into instruction memory.
- Once loading completes, it restarts and starts the CPU, then watches the controller's stop (HALT) flag.
- Reports halt status and the run-cycle count back to the host.

---
 rtl/mpu_pkg.sv | 6 +
 rtl/pulse_stretch.sv | 17 +
 rtl/prog_loader.sv | 83 ++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared MPU state encoding and width defaults
package mpu_pkg;
  localparam int MPU_AW = 8;
  localparam int MPU_DW = 8;
  typedef enum logic [2:0] {IDLE, LOAD, RESTART, START, RUN, HALTED} state_t;
endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: down-counter holding a phase for N cycles after a trigger
module pulse_stretch #(
  parameter int N = 2
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic trig,
  output logic last
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt;
  // load N on trigger, then count down to zero and rest there
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= trig ? W'(N) : cnt - W'(cnt != '0);
  assign last = cnt == W'(1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed program into imem, then restarts, starts and monitors the CPU
module prog_loader
  import mpu_pkg::*;
#(
  parameter int AW = MPU_AW,
  parameter int DW = MPU_DW,
  parameter int BASE_ADDR = 0,
  parameter int RST_CYCLES = 2,
  parameter int START_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             cpu_restart,
  output logic             cpu_start,
  input  logic             cpu_stop,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] run_cycles
);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  state_t state, nxt;
  logic [DW-1:0] count;
  logic [AW-1:0] addr;
  logic acc, rst_trig, st_trig, rst_last, st_last;
  assign in_ready = state inside {IDLE, LOAD, HALTED};
  assign busy = state inside {LOAD, RESTART, START, RUN};
  assign acc = in_valid && in_ready;
  assign rst_trig = nxt == RESTART && state != RESTART;
  assign st_trig = nxt == START && state != START;
  pulse_stretch #(.N(RST_CYCLES)) u_rst (.clkin(clkin), .rst_n(rst_n), .trig(rst_trig), .last(rst_last));
  pulse_stretch #(.N(START_CYCLES)) u_start (.clkin(clkin), .rst_n(rst_n), .trig(st_trig), .last(st_last));
  // next-state: a length byte of zero reruns the resident program without loading
  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALTED: if (acc) nxt = (in_data == '0) ? RESTART : LOAD;
      LOAD:         if (acc && count == DW'(1)) nxt = RESTART;
      RESTART:      if (rst_last) nxt = START;
      START:        if (st_last) nxt = RUN;
      RUN:          if (cpu_stop) nxt = HALTED;
      default:      nxt = IDLE;
    endcase
  end
  // state, load bookkeeping and registered outputs; control levels follow the state being entered
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      addr        <= BASE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      cpu_restart <= 1'b1;
      cpu_start   <= 1'b0;
      halted      <= 1'b0;
      run_cycles  <= '0;
    end else begin
      state       <= nxt;
      mem_we      <= acc && state == LOAD;
      cpu_restart <= nxt inside {IDLE, LOAD, RESTART};
      cpu_start   <= nxt == START;
      halted      <= nxt == HALTED || (halted && !rst_trig);
      if (acc && state != LOAD) begin
        count <= in_data;
        addr  <= BASE;
      end
      if (acc && state == LOAD) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
        addr      <= addr + AW'(1);
        count     <= count - DW'(1);
      end
      if (rst_trig) run_cycles <= '0;
      else if (state == RUN && !(&run_cycles)) run_cycles <= run_cycles + CNT_W'(1);
    end
endmodule
